// File: rtl/shared_sram_arb_mem.sv
// Shared single-port SRAM bank behind a round-robin arbiter. Each request gets a
// fixed-latency response with relocation and out-of-range error reporting.
module shared_sram_arb_mem #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned Depth = 1 << 20,
  parameter int unsigned ReadLatency = 1,
  parameter logic [AddrWidth-1:0] BaseAddr = AddrWidth'(32'h8000_0000)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             req_i,
  output logic [NumPorts-1:0]             gnt_o,
  input  logic [NumPorts*AddrWidth-1:0]   addr_i,
  input  logic [NumPorts-1:0]             we_i,
  input  logic [NumPorts*DataWidth-1:0]   wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0] strb_i,
  output logic [NumPorts-1:0]             rvalid_o,
  output logic [NumPorts*DataWidth-1:0]   rdata_o,
  output logic [NumPorts-1:0]             err_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(StrbWidth);
  localparam int unsigned PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth:0] DepthWords = (AddrWidth + 1)'(Depth);

  if (NumPorts < 1 || NumPorts > 8 || !(DataWidth == 32 || DataWidth == 64) ||
      ReadLatency < 1 || ReadLatency > 4 || Depth == 0 || (Depth & (Depth - 1)) != 0 ||
      AddrWidth <= OffWidth ||
      64'(Depth) > (64'd1 << (AddrWidth - OffWidth))) begin : g_bad_params
    $error("shared_sram_arb_mem: illegal parameter combination");
  end

  function automatic logic [PtrWidth-1:0] wrap(input int unsigned v);
    return PtrWidth'(v % NumPorts);
  endfunction

  logic [PtrWidth-1:0]  ptr;
  logic [PtrWidth-1:0]  sel;
  logic                 any;
  logic [AddrWidth-1:0] addr;
  logic [AddrWidth-1:0] off;
  logic [AddrWidth-1:0] idx_full;
  logic [IdxWidth-1:0]  idx;
  logic                 in_range;
  logic                 we;
  logic [DataWidth-1:0] wdata;
  logic [StrbWidth-1:0] strb;
  logic [DataWidth-1:0] n_data;
  logic                 h_valid;
  logic                 h_err;
  logic [PtrWidth-1:0]  h_port;
  logic [DataWidth-1:0] h_data;

  logic [DataWidth-1:0] mem [Depth];

  // Downward scan so the lowest cyclic distance from ptr wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (!rst_i && req_i[wrap(32'(ptr) + 32'(i))]) begin
        sel = wrap(32'(ptr) + 32'(i));
        any = 1'b1;
      end
    end
  end

  assign gnt_o = any ? (NumPorts'(1) << sel) : '0;

  always_comb begin
    addr     = addr_i[sel*AddrWidth +: AddrWidth];
    we       = we_i[sel];
    wdata    = wdata_i[sel*DataWidth +: DataWidth];
    strb     = strb_i[sel*StrbWidth +: StrbWidth];
    off      = addr - BaseAddr;
    idx_full = off >> OffWidth;
    in_range = (addr >= BaseAddr) && ({1'b0, idx_full} < DepthWords);
    idx      = idx_full[IdxWidth-1:0];
  end

  assign n_data = (any && in_range && !we) ? mem[idx] : '0;

  always_ff @(posedge clk_i) begin
    if (any && in_range && we) begin
      for (int b = 0; b < int'(StrbWidth); b++) begin
        if (strb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Stages between the grant edge and the output registers.
  if (ReadLatency > 1) begin : g_pipe
    localparam int Stages = int'(ReadLatency) - 1;
    logic [Stages-1:0]    v;
    logic [Stages-1:0]    e;
    logic [PtrWidth-1:0]  p [Stages];
    logic [DataWidth-1:0] d [Stages];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v <= '0;
      end else begin
        for (int s = Stages - 1; s > 0; s--) begin
          v[s] <= v[s-1];
          e[s] <= e[s-1];
          p[s] <= p[s-1];
          d[s] <= d[s-1];
        end
        v[0] <= any;
        e[0] <= !in_range;
        p[0] <= sel;
        d[0] <= n_data;
      end
    end

    assign h_valid = v[Stages-1];
    assign h_err   = e[Stages-1];
    assign h_port  = p[Stages-1];
    assign h_data  = d[Stages-1];
  end else begin : g_direct
    assign h_valid = any;
    assign h_err   = !in_range;
    assign h_port  = sel;
    assign h_data  = n_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= '0;
      ptr      <= '0;
    end else begin
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= '0;
      if (h_valid) begin
        rvalid_o[h_port]                       <= 1'b1;
        err_o[h_port]                          <= h_err;
        rdata_o[h_port*DataWidth +: DataWidth] <= h_data;
      end
      if (any) ptr <= wrap(32'(sel) + 32'd1);
    end
  end
endmodule

// File: tb/tb_shared_sram_arb_mem.sv
// Scoreboard bench: two instances (latency 1 and 3) see identical stimulus and
// are compared each cycle against a word-array reference model.
module tb_shared_sram_arb_mem;
  localparam int unsigned NP = 3;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    int          due;
    int          port;
    bit          err;
    logic [63:0] data;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req;
  logic [NP-1:0]    we;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [NP*8-1:0]  strb;
  logic [NP-1:0]    gnt_w [2];
  logic [NP-1:0]    rv_w [2];
  logic [NP-1:0]    er_w [2];
  logic [NP*DW-1:0] rd_w [2];

  always #5 clk = ~clk;

  shared_sram_arb_mem #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH),
                        .ReadLatency(1), .BaseAddr(BASE)) u_rl1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_w[0]), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rv_w[0]), .rdata_o(rd_w[0]), .err_o(er_w[0]));

  shared_sram_arb_mem #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH),
                        .ReadLatency(3), .BaseAddr(BASE)) u_rl3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt_w[1]), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rv_w[1]), .rdata_o(rd_w[1]), .err_o(er_w[1]));

  bit          pend [NP];
  bit          pw [NP];
  logic [31:0] pa [NP];
  logic [63:0] pd [NP];
  logic [7:0]  ps [NP];
  logic [63:0] model_mem [int];
  resp_t       q [2][$];
  int          mptr;
  int          edges;
  int          checks;
  int          errors;
  bit          mon_on;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic load(input int p, input bit w, input logic [31:0] a,
                      input logic [63:0] d, input logic [7:0] s);
    pend[p] = 1'b1;
    pw[p]   = w;
    pa[p]   = a;
    pd[p]   = d;
    ps[p]   = s;
  endtask

  // Reference behaviour of one granted request; response queued for both latencies.
  task automatic respond(input int g);
    resp_t       r;
    int          idx;
    logic [63:0] m;
    r.port = g;
    r.err  = 1'b0;
    r.data = '0;
    if (pa[g] < BASE || ((pa[g] - BASE) >> 3) >= 32'(DEPTH)) begin
      r.err = 1'b1;
    end else begin
      idx = int'((pa[g] - BASE) >> 3);
      if (pw[g]) begin
        m = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
        for (int b = 0; b < 8; b++) if (ps[g][b]) m[b*8 +: 8] = pd[g][b*8 +: 8];
        model_mem[idx] = m;
      end else begin
        r.data = model_mem.exists(idx) ? model_mem[idx] : 64'h0;
      end
    end
    r.due = edges;
    q[0].push_back(r);
    r.due = edges + 2;
    q[1].push_back(r);
  endtask

  // One clock: drive at negedge, check grant, advance model at posedge.
  task automatic step();
    int            g;
    logic [NP-1:0] eg;
    for (int p = 0; p < int'(NP); p++) begin
      req[p]             = pend[p];
      we[p]              = pw[p];
      addr[p*AW +: AW]   = pa[p];
      wdata[p*DW +: DW]  = pd[p];
      strb[p*8 +: 8]     = ps[p];
    end
    #1;
    g = -1;
    if (!rst) begin
      for (int i = 0; i < int'(NP); i++) begin
        if (g < 0 && pend[(mptr + i) % NP]) g = (mptr + i) % NP;
      end
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt_rl1", 256'(gnt_w[0]), 256'(eg));
    chk("gnt_rl3", 256'(gnt_w[1]), 256'(eg));
    @(posedge clk);
    edges++;
    if (rst) begin
      mptr = 0;
      for (int u = 0; u < 2; u++) begin
        while (q[u].size() > 0 && q[u][$].due >= edges) void'(q[u].pop_back());
      end
    end else if (g >= 0) begin
      respond(g);
      mptr = (g + 1) % NP;
      pend[g] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((pend[0] || pend[1] || pend[2]) && n < 60) begin
      step();
      n++;
    end
    chk("settle_timeout", 256'(pend[0] || pend[1] || pend[2]), 256'(0));
  endtask

  task automatic issue(input int p, input bit w, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    load(p, w, a, d, s);
    settle();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 15) return BASE + 32'(r * 8) + 32'($urandom_range(0, 7));
    if (r == 15) return BASE + 32'((DEPTH - 1) * 8) + 32'($urandom_range(0, 7));
    if (r == 16) return 32'h7FFF_FFF8;
    if (r == 17) return BASE + 32'(DEPTH * 8);
    if (r == 18) return 32'hFFFF_FFF8;
    return 32'h0000_0010;
  endfunction

  always @(negedge clk) begin : monitor
    resp_t            r;
    logic [NP-1:0]    ev;
    logic [NP-1:0]    ee;
    logic [NP*DW-1:0] ed;
    if (mon_on) begin
      for (int u = 0; u < 2; u++) begin
        ev = '0;
        ee = '0;
        ed = '0;
        if (q[u].size() > 0 && q[u][0].due == edges) begin
          r = q[u].pop_front();
          ev[r.port] = 1'b1;
          ee[r.port] = r.err;
          ed[r.port*DW +: DW] = r.data;
        end
        chk($sformatf("rvalid_rl%0d", 2*u + 1), 256'(rv_w[u]), 256'(ev));
        chk($sformatf("err_rl%0d", 2*u + 1), 256'(er_w[u]), 256'(ee));
        chk($sformatf("rdata_rl%0d", 2*u + 1), 256'(rd_w[u]), 256'(ed));
      end
    end
  end

  initial begin
    rst = 1'b1;
    mon_on = 1'b0;
    mptr = 0;
    edges = 0;
    checks = 0;
    errors = 0;
    for (int p = 0; p < int'(NP); p++) load(p, 1'b0, 32'h0, 64'h0, 8'h0);
    for (int p = 0; p < int'(NP); p++) pend[p] = 1'b0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    mon_on = 1'b1;
    step();

    // Give every word the random traffic can reach a known value.
    for (int i = 0; i < 16; i++) begin
      issue(i % NP, 1'b1, BASE + 32'((i < 15 ? i : int'(DEPTH) - 1) * 8),
            {$urandom, $urandom}, 8'hFF);
    end

    issue(0, 1'b1, 32'h8000_0008, 64'hDEADBEEF_01234567, 8'hFF);
    issue(0, 1'b0, 32'h8000_0008, 64'h0, 8'h00);
    issue(0, 1'b1, 32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    issue(0, 1'b0, 32'h8000_0008, 64'h0, 8'h00);
    step();
    step();
    step();

    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) load(p, 1'b0, BASE + 32'(8 * ((c + p) % 4)), 64'h0, 8'h00);
      end
      step();
    end
    settle();

    issue(0, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00);
    issue(1, 1'b0, BASE + 32'(DEPTH * 8), 64'h0, 8'h00);
    issue(2, 1'b1, BASE + 32'(DEPTH * 8), 64'h1234_5678_9ABC_DEF0, 8'hFF);
    issue(2, 1'b1, 32'h7FFF_FFF8, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    issue(1, 1'b0, BASE, 64'h0, 8'h00);
    issue(0, 1'b0, BASE + 32'((DEPTH - 1) * 8), 64'h0, 8'h00);

    issue(1, 1'b0, BASE + 32'h10, 64'h0, 8'h00);
    rst = 1'b1;
    load(0, 1'b0, BASE + 32'h18, 64'h0, 8'h00);
    load(2, 1'b1, BASE + 32'h20, 64'h5555_AAAA_5555_AAAA, 8'hFF);
    step();
    rst = 1'b0;
    step();
    settle();
    issue(1, 1'b0, BASE + 32'h20, 64'h0, 8'h00);

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < int'(NP); p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          load(p, $urandom_range(0, 2) == 0, rand_addr(), {$urandom, $urandom},
               8'($urandom_range(0, 255)));
        end
      end
      step();
    end
    rst = 1'b0;
    settle();
    for (int c = 0; c < 6; c++) step();
    chk("drain_rl1", 256'(q[0].size()), 256'(0));
    chk("drain_rl3", 256'(q[1].size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
